// File: rtl/tcp_rx_fetch_ul.sv
// -----------------------------------------------------------------------------
// tcp_rx_fetch_ul
//
// User-side receive engine. It takes one TCP data notification at a time and
// fetches the announced payload from the stack:
//   - splits the notified length into read-package requests of at most
//     PKG_BYTES bytes each,
//   - accepts the rx-meta that answers each request,
//   - passes the payload beats straight through to the user with zero latency.
//     Only the final beat of the whole notification carries tlast downstream.
//   - reports one completion record per notification. Closed notifications
//     produce a record without fetching; zero-length notifications are dropped.
//
// Ports (all channels valid/ready, single clock aclk, async active-low aresetn)
//   s_tcp_notify_*   in  88b  {ign[87:81], closed[80], dst_port[79:64],
//                              ip[63:32], len[31:16], sid[15:0]}
//   m_tcp_rd_pkg_*   out 40b  {8'h0, len[31:16], sid[15:0]}
//   s_tcp_rx_meta_*  in  16b  sid
//   s_axis_tcp_rx_*  in  AXI4-Stream 512b data, 64b keep, last (from stack)
//   m_axis_tcp_rx_*  out AXI4-Stream 512b data, 64b keep, last (to user)
//   m_rx_done_*      out 40b  {6'h0, err[33], closed[32], bytes[31:16], sid[15:0]}
// -----------------------------------------------------------------------------
module tcp_rx_fetch_ul #(
  parameter int unsigned PKG_BYTES = 1024
) (
  input  logic         aclk,
  input  logic         aresetn,

  input  logic         s_tcp_notify_valid,
  output logic         s_tcp_notify_ready,
  input  logic [87:0]  s_tcp_notify_data,

  output logic         m_tcp_rd_pkg_valid,
  input  logic         m_tcp_rd_pkg_ready,
  output logic [39:0]  m_tcp_rd_pkg_data,

  input  logic         s_tcp_rx_meta_valid,
  output logic         s_tcp_rx_meta_ready,
  input  logic [15:0]  s_tcp_rx_meta_data,

  input  logic         s_axis_tcp_rx_tvalid,
  output logic         s_axis_tcp_rx_tready,
  input  logic [511:0] s_axis_tcp_rx_tdata,
  input  logic [63:0]  s_axis_tcp_rx_tkeep,
  input  logic         s_axis_tcp_rx_tlast,

  output logic         m_axis_tcp_rx_tvalid,
  input  logic         m_axis_tcp_rx_tready,
  output logic [511:0] m_axis_tcp_rx_tdata,
  output logic [63:0]  m_axis_tcp_rx_tkeep,
  output logic         m_axis_tcp_rx_tlast,

  output logic         m_rx_done_valid,
  input  logic         m_rx_done_ready,
  output logic [39:0]  m_rx_done_data
);

  localparam logic [15:0] PKG_LEN = 16'(PKG_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_META,
    ST_DATA,
    ST_DONE
  } state_e;

  // Number of valid bytes in a 64-byte beat (0..64).
  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] acc;
    acc = '0;
    for (int i = 0; i < 64; i++) begin
      acc = acc + {6'b0, v[i]};
    end
    return acc;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q,  state_d;
  logic [15:0] sid_q,    sid_d;
  logic [15:0] len_q,    len_d;     // notified length, for the completion check
  logic [15:0] rem_q,    rem_d;     // bytes not yet requested
  logic [16:0] cnt_q,    cnt_d;     // bytes received; bit 16 = overflow
  logic        err_q,    err_d;
  logic        closed_q, closed_d;
  logic        run_q;               // low from reset until the first clock edge

  // ---------------------------------------------------------------------------
  // Field extraction and handshakes
  // ---------------------------------------------------------------------------
  logic [15:0] ntf_sid;
  logic [15:0] ntf_len;
  logic        ntf_closed;
  logic        unused_ntf_bits;

  assign ntf_sid         = s_tcp_notify_data[15:0];
  assign ntf_len         = s_tcp_notify_data[31:16];
  assign ntf_closed      = s_tcp_notify_data[80];
  assign unused_ntf_bits = ^{s_tcp_notify_data[87:81], s_tcp_notify_data[79:32]};

  logic in_idle, in_req, in_meta, in_data, in_done;
  assign in_idle = (state_q == ST_IDLE);
  assign in_req  = (state_q == ST_REQ);
  assign in_meta = (state_q == ST_META);
  assign in_data = (state_q == ST_DATA);
  assign in_done = (state_q == ST_DONE);

  logic notify_hs, rd_pkg_hs, meta_hs, beat_hs, done_hs;
  assign notify_hs = s_tcp_notify_valid  && s_tcp_notify_ready;
  assign rd_pkg_hs = m_tcp_rd_pkg_valid  && m_tcp_rd_pkg_ready;
  assign meta_hs   = s_tcp_rx_meta_valid && s_tcp_rx_meta_ready;
  assign beat_hs   = s_axis_tcp_rx_tvalid && s_axis_tcp_rx_tready;
  assign done_hs   = m_rx_done_valid     && m_rx_done_ready;

  // Size of the next read-package request (16-bit unsigned min).
  logic [15:0] chunk;
  assign chunk = (rem_q < PKG_LEN) ? rem_q : PKG_LEN;

  logic [6:0] beat_bytes;
  assign beat_bytes = popcount64(s_axis_tcp_rx_tkeep);

  // Short, long or overflowed delivery is reported as an error unless the
  // notification was a close, which never fetches any data.
  logic done_err;
  assign done_err = err_q | cnt_q[16] | (!closed_q && (cnt_q != {1'b0, len_q}));

  // ---------------------------------------------------------------------------
  // Channel outputs. Valids depend only on state, never on the matching ready.
  // Data outputs are forced to zero whenever their channel is idle.
  // ---------------------------------------------------------------------------
  assign s_tcp_notify_ready   = run_q && in_idle;

  assign m_tcp_rd_pkg_valid   = in_req;
  assign m_tcp_rd_pkg_data    = in_req ? {8'h00, chunk, sid_q} : '0;

  assign s_tcp_rx_meta_ready  = in_meta;

  assign s_axis_tcp_rx_tready = in_data && m_axis_tcp_rx_tready;
  assign m_axis_tcp_rx_tvalid = in_data && s_axis_tcp_rx_tvalid;
  assign m_axis_tcp_rx_tdata  = in_data ? s_axis_tcp_rx_tdata : '0;
  assign m_axis_tcp_rx_tkeep  = in_data ? s_axis_tcp_rx_tkeep : '0;
  // Per-chunk tlast from the stack only ends the user packet on the last chunk.
  assign m_axis_tcp_rx_tlast  = in_data && s_axis_tcp_rx_tlast && (rem_q == 16'd0);

  assign m_rx_done_valid      = in_done;
  assign m_rx_done_data       = in_done ? {6'b0, done_err, closed_q, cnt_q[15:0], sid_q} : '0;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable written here gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    sid_d    = sid_q;
    len_d    = len_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    closed_d = closed_q;

    unique case (state_q)
      ST_IDLE: begin
        if (notify_hs) begin
          sid_d = ntf_sid;
          len_d = ntf_len;
          cnt_d = '0;
          err_d = 1'b0;
          if (ntf_closed) begin
            closed_d = 1'b1;
            state_d  = ST_DONE;
          end else if (ntf_len != 16'd0) begin
            rem_d    = ntf_len;
            closed_d = 1'b0;
            state_d  = ST_REQ;
          end
          // A zero-length data notification is dropped: stay in IDLE.
        end
      end

      ST_REQ: begin
        if (rd_pkg_hs) begin
          rem_d   = rem_q - chunk;
          state_d = ST_META;
        end
      end

      ST_META: begin
        if (meta_hs) begin
          if (s_tcp_rx_meta_data != sid_q) begin
            err_d = 1'b1;
          end
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (beat_hs) begin
          cnt_d = cnt_q + {10'b0, beat_bytes};
          // Keep the overflow bit sticky even if the count wraps further.
          cnt_d[16] = cnt_d[16] | cnt_q[16];
          if (s_axis_tcp_rx_tlast) begin
            state_d = (rem_q != 16'd0) ? ST_REQ : ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (done_hs) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      sid_q    <= '0;
      len_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      closed_q <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sid_q    <= sid_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      closed_q <= closed_d;
      run_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tcp_rx_fetch_ul.sv
// -----------------------------------------------------------------------------
// tb_tcp_rx_fetch_ul
//
// Directed bench for tcp_rx_fetch_ul (PKG_BYTES = 1024). Inputs are driven just
// after the rising edge and outputs are sampled a further #1 later, so every
// sample sees settled combinational values well away from the active edge.
// -----------------------------------------------------------------------------
module tb_tcp_rx_fetch_ul;

  localparam int          TMO      = 50;
  localparam logic [63:0] KEEP_ALL = '1;

  logic         aclk = 1'b0;
  logic         aresetn;

  logic         notify_valid, notify_ready;
  logic [87:0]  notify_data;
  logic         rd_valid, rd_ready;
  logic [39:0]  rd_data;
  logic         meta_valid, meta_ready;
  logic [15:0]  meta_data;
  logic         s_tvalid, s_tready, s_tlast;
  logic [511:0] s_tdata;
  logic [63:0]  s_tkeep;
  logic         m_tvalid, m_tready, m_tlast;
  logic [511:0] m_tdata;
  logic [63:0]  m_tkeep;
  logic         done_valid, done_ready;
  logic [39:0]  done_data;

  int checks = 0;
  int errors = 0;

  tcp_rx_fetch_ul #(.PKG_BYTES(1024)) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_tcp_notify_valid   (notify_valid),
    .s_tcp_notify_ready   (notify_ready),
    .s_tcp_notify_data    (notify_data),
    .m_tcp_rd_pkg_valid   (rd_valid),
    .m_tcp_rd_pkg_ready   (rd_ready),
    .m_tcp_rd_pkg_data    (rd_data),
    .s_tcp_rx_meta_valid  (meta_valid),
    .s_tcp_rx_meta_ready  (meta_ready),
    .s_tcp_rx_meta_data   (meta_data),
    .s_axis_tcp_rx_tvalid (s_tvalid),
    .s_axis_tcp_rx_tready (s_tready),
    .s_axis_tcp_rx_tdata  (s_tdata),
    .s_axis_tcp_rx_tkeep  (s_tkeep),
    .s_axis_tcp_rx_tlast  (s_tlast),
    .m_axis_tcp_rx_tvalid (m_tvalid),
    .m_axis_tcp_rx_tready (m_tready),
    .m_axis_tcp_rx_tdata  (m_tdata),
    .m_axis_tcp_rx_tkeep  (m_tkeep),
    .m_axis_tcp_rx_tlast  (m_tlast),
    .m_rx_done_valid      (done_valid),
    .m_rx_done_ready      (done_ready),
    .m_rx_done_data       (done_data)
  );

  always #5 aclk = ~aclk;

  // ---------------------------------------------------------------------------
  // Comparison helpers
  // ---------------------------------------------------------------------------
  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check40(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] done_rec(input logic [15:0] sid, input logic [15:0] bytes,
                                           input logic closed, input logic err);
    return {6'b0, err, closed, bytes, sid};
  endfunction

  function automatic logic [87:0] notify_word(input logic [15:0] sid, input logic [15:0] len,
                                              input logic closed);
    // Ignored top bits carry junk to show they have no effect.
    return {7'h55, closed, 16'h1F90, 32'hC0A8_0001, len, sid};
  endfunction

  // ---------------------------------------------------------------------------
  // Channel tasks. Each returns #1 after the edge that completed its handshake.
  // ---------------------------------------------------------------------------
  task automatic send_notify(input logic [15:0] sid, input logic [15:0] len, input logic closed);
    int n = 0;
    notify_valid = 1'b1;
    notify_data  = notify_word(sid, len, closed);
    #1;
    while (!notify_ready && n < TMO) begin
      @(posedge aclk); #2; n++;
    end
    check_bit("notify_accept", notify_ready, 1'b1);
    @(posedge aclk); #1;
    notify_valid = 1'b0;
  endtask

  task automatic take_rd_pkg(input logic [15:0] sid, input logic [15:0] len, input int stall);
    int n = 0;
    #1;
    while (!rd_valid && n < TMO) begin
      @(posedge aclk); #2; n++;
    end
    check_bit("rd_pkg_valid", rd_valid, 1'b1);
    check40("rd_pkg_data", rd_data, {8'h00, len, sid});
    repeat (stall) begin
      @(posedge aclk); #2;
      check40("rd_pkg_hold", rd_data, {8'h00, len, sid});
      check_bit("rd_pkg_hold_valid", rd_valid, 1'b1);
    end
    rd_ready = 1'b1;
    @(posedge aclk); #1;
    rd_ready = 1'b0;
  endtask

  task automatic send_meta(input logic [15:0] sid);
    int n = 0;
    meta_valid = 1'b1;
    meta_data  = sid;
    #1;
    while (!meta_ready && n < TMO) begin
      @(posedge aclk); #2; n++;
    end
    check_bit("meta_accept", meta_ready, 1'b1);
    @(posedge aclk); #1;
    meta_valid = 1'b0;
  endtask

  // One beat, optionally preceded by idle cycles and user-side back-pressure.
  task automatic send_beat(input logic [63:0] keep, input logic last, input logic exp_last,
                           input int gaps, input int stall);
    logic [511:0] d;
    d = {16{$urandom()}};
    repeat (gaps) begin
      #1;
      check_bit("gap_tvalid", m_tvalid, 1'b0);
      @(posedge aclk); #1;
    end
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = keep;
    s_tlast  = last;
    m_tready = 1'b0;
    repeat (stall) begin
      #1;
      check_bit("stall_tready", s_tready, 1'b0);
      @(posedge aclk); #1;
    end
    m_tready = 1'b1;
    #1;
    check_bit("beat_tvalid", m_tvalid, 1'b1);
    check_bit("beat_tready", s_tready, 1'b1);
    check_bit("beat_tdata", m_tdata === d, 1'b1);
    check64("beat_tkeep", m_tkeep, keep);
    check_bit("beat_tlast", m_tlast, exp_last);
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
  endtask

  task automatic take_done(input logic [39:0] exp, input int stall);
    int n = 0;
    #1;
    while (!done_valid && n < TMO) begin
      @(posedge aclk); #2; n++;
    end
    check_bit("done_valid", done_valid, 1'b1);
    check40("done_data", done_data, exp);
    repeat (stall) begin
      @(posedge aclk); #2;
      check40("done_hold", done_data, exp);
    end
    done_ready = 1'b1;
    @(posedge aclk); #1;
    done_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  logic [15:0] lens [3];
  logic [63:0] keep;
  int          nb;

  initial begin
    lens = '{16'd1024, 16'd1024, 16'd452};
    aresetn      = 1'b0;
    notify_valid = 1'b0; notify_data = '0;
    rd_ready     = 1'b0;
    meta_valid   = 1'b0; meta_data   = '0;
    s_tvalid     = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    m_tready     = 1'b0;
    done_ready   = 1'b0;

    // Reset state.
    repeat (3) @(posedge aclk);
    #1;
    check_bit("rst_notify_ready", notify_ready, 1'b0);
    check_bit("rst_rd_valid", rd_valid, 1'b0);
    check_bit("rst_meta_ready", meta_ready, 1'b0);
    check_bit("rst_done_valid", done_valid, 1'b0);
    check40("rst_rd_data", rd_data, 40'h0);
    check40("rst_done_data", done_data, 40'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check_bit("rel_before_edge", notify_ready, 1'b0);
    @(posedge aclk); #1;
    check_bit("rel_ready", notify_ready, 1'b1);

    // Single chunk, with early rx_meta back-pressured during REQ.
    send_notify(16'd5, 16'd128, 1'b0);
    #1;
    check_bit("t1_rd_latency", rd_valid, 1'b1);
    meta_valid = 1'b1;
    meta_data  = 16'd5;
    #1;
    check_bit("t1_meta_bp", meta_ready, 1'b0);
    take_rd_pkg(16'd5, 16'd128, 2);
    #1;
    check_bit("t1_meta_latency", meta_ready, 1'b1);
    @(posedge aclk); #1;
    meta_valid = 1'b0;
    send_beat(KEEP_ALL, 1'b0, 1'b0, 0, 0);
    send_beat(KEEP_ALL, 1'b1, 1'b1, 0, 1);
    #1;
    check_bit("t1_done_latency", done_valid, 1'b1);
    take_done(done_rec(16'd5, 16'd128, 1'b0, 1'b0), 2);
    #1;
    check_bit("t1_ready_back", notify_ready, 1'b1);

    // Multi-chunk 2500 bytes with stalls; a closed notify waits during DATA.
    send_notify(16'd7, 16'd2500, 1'b0);
    for (int c = 0; c < 3; c++) begin
      take_rd_pkg(16'd7, lens[c], c);
      send_meta(16'd7);
      nb = (c == 2) ? 8 : 16;
      if (c == 2) begin
        notify_valid = 1'b1;
        notify_data  = notify_word(16'd9, 16'd0, 1'b1);
      end
      for (int b = 0; b < nb; b++) begin
        keep = (c == 2 && b == nb - 1) ? 64'hF : KEEP_ALL;
        send_beat(keep, b == nb - 1, (c == 2) && (b == nb - 1),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        if (c == 2 && b == 0) begin
          #1;
          check_bit("t2_notify_bp", notify_ready, 1'b0);
        end
      end
    end
    take_done(done_rec(16'd7, 16'd2500, 1'b0, 1'b0), 1);
    #1;
    check_bit("t2_second_ready", notify_ready, 1'b1);
    @(posedge aclk); #1;
    notify_valid = 1'b0;

    // Closed notification: record without any rd_pkg.
    #1;
    check_bit("t3_closed_no_rd", rd_valid, 1'b0);
    take_done(done_rec(16'd9, 16'd0, 1'b1, 1'b0), 0);

    // Zero-length notification: dropped, no rd_pkg, no record.
    send_notify(16'd3, 16'd0, 1'b0);
    #1;
    check_bit("t4_len0_no_rd", rd_valid, 1'b0);
    check_bit("t4_len0_no_done", done_valid, 1'b0);
    check_bit("t4_len0_idle", notify_ready, 1'b1);
    repeat (2) @(posedge aclk);
    #1;
    check_bit("t4_len0_still_no_done", done_valid, 1'b0);

    // rx_meta carrying the wrong sid.
    send_notify(16'd5, 16'd64, 1'b0);
    take_rd_pkg(16'd5, 16'd64, 0);
    send_meta(16'd6);
    send_beat(KEEP_ALL, 1'b1, 1'b1, 0, 0);
    take_done(done_rec(16'd5, 16'd64, 1'b0, 1'b1), 0);

    // Short delivery: 64 + 36 = 100 of 128 bytes.
    send_notify(16'd5, 16'd128, 1'b0);
    take_rd_pkg(16'd5, 16'd128, 0);
    send_meta(16'd5);
    send_beat(KEEP_ALL, 1'b0, 1'b0, 0, 0);
    send_beat(64'h0000_000F_FFFF_FFFF, 1'b1, 1'b1, 0, 0);
    take_done(done_rec(16'd5, 16'd100, 1'b0, 1'b1), 0);

    // Empty-keep beat is forwarded and adds nothing.
    send_notify(16'd2, 16'd64, 1'b0);
    take_rd_pkg(16'd2, 16'd64, 0);
    send_meta(16'd2);
    send_beat(64'h0, 1'b0, 1'b0, 0, 0);
    send_beat(KEEP_ALL, 1'b1, 1'b1, 0, 0);
    take_done(done_rec(16'd2, 16'd64, 1'b0, 1'b0), 0);

    // Reset pulsed mid-DATA.
    send_notify(16'd4, 16'd128, 1'b0);
    take_rd_pkg(16'd4, 16'd128, 0);
    send_meta(16'd4);
    send_beat(KEEP_ALL, 1'b0, 1'b0, 0, 0);
    s_tvalid = 1'b1;
    s_tdata  = {16{32'hA5A5_0F0F}};
    s_tkeep  = KEEP_ALL;
    m_tready = 1'b1;
    #1;
    check_bit("t7_pre_tvalid", m_tvalid, 1'b1);
    aresetn = 1'b0;
    #1;
    check_bit("t7_rst_m_tvalid", m_tvalid, 1'b0);
    check_bit("t7_rst_s_tready", s_tready, 1'b0);
    check_bit("t7_rst_notify_ready", notify_ready, 1'b0);
    check_bit("t7_rst_rd_valid", rd_valid, 1'b0);
    check_bit("t7_rst_meta_ready", meta_ready, 1'b0);
    check_bit("t7_rst_done_valid", done_valid, 1'b0);
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check_bit("t7_ready_after", notify_ready, 1'b1);
    check_bit("t7_no_done", done_valid, 1'b0);

    // Clean transaction after the abort.
    send_notify(16'd1, 16'd64, 1'b0);
    take_rd_pkg(16'd1, 16'd64, 0);
    send_meta(16'd1);
    send_beat(KEEP_ALL, 1'b1, 1'b1, 0, 0);
    take_done(done_rec(16'd1, 16'd64, 1'b0, 1'b0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tcp_rx_fetch_ul.md
# tcp_rx_fetch_ul

User-side receive engine that consumes TCP stack notifications and fetches the announced payload. It turns each data notification into one or more read-package requests of at most `PKG_BYTES` bytes. It accepts the matching rx-meta and forwards the payload stream to user logic as one packet per notification. It sits on the user side of the TCP slice array and drives the notify / rd_pkg / rx_meta / rx-data channels from the user end, then reports one completion record per notification.

## Interface
- `PKG_BYTES`, default 1024: maximum bytes per rd_pkg request. Power of two, range 64..32768.
- `aclk`  in  1  single clock for all logic.
- `aresetn`  in  1  asynchronous, active-low reset.
- `s_tcp_notify`  metaIntf.s  88  field layout:
  - sid[15:0], len[31:16], ip[63:32], dst_port[79:64], closed[80].
  - Bits [87:81] are ignored.
- `m_tcp_rd_pkg`  metaIntf.m  40  sid[15:0], len[31:16]; bits [39:32] driven 0.
- `s_tcp_rx_meta`  metaIntf.s  16  sid[15:0].
- `s_axis_tcp_rx`  AXI4S.s  512  payload from the stack: tdata, tkeep[63:0], tlast.
- `m_axis_tcp_rx`  AXI4S.m  512  payload to the user: tdata, tkeep, tlast.
- `m_rx_done`  metaIntf.m  40  completion record:
  - sid[15:0], bytes[31:16], closed[32], err[33].
  - Bits [39:34] driven 0.

## Operation
- Registers:
  - `sid_q` (16 bits).
  - `rem_q` (16 bits): bytes not yet requested.
  - `cnt_q` (17 bits): bytes received.
  - `err_q`: sticky error flag.
  - `closed_q`.
- States and transitions:
  - IDLE: `s_tcp_notify.ready`=1. On handshake, latch sid, clear cnt_q, clear err_q, and select the next state:
    - closed=1: set closed_q and go to DONE.
    - len=0: drop the notification and stay in IDLE.
    - otherwise: rem_q=len, closed_q=0, go to REQ.
  - REQ: `m_tcp_rd_pkg.valid`=1 with {sid_q, chunk}, where chunk = min(rem_q, PKG_BYTES). On handshake, rem_q -= chunk and go to META.
  - META: `s_tcp_rx_meta.ready`=1. On handshake, set err_q if meta sid ≠ sid_q, then go to DATA.
  - DATA: combinational pass-through.
    - tvalid and tdata/tkeep go downstream; tready comes upstream.
    - `m_axis_tcp_rx.tlast` = `s_axis_tcp_rx.tlast` && rem_q==0.
    - On each beat handshake, cnt_q += popcount(tkeep), a 0..64 increment.
    - On a tlast handshake, go to REQ if rem_q≠0, else go to DONE.
  - DONE: `m_rx_done.valid`=1 with data {sid_q, cnt_q[15:0], closed_q, err}.
    - err = err_q | (closed_q=0 && cnt_q ≠ notified len).
    - On handshake, go to IDLE.
- The notified len is held in a 16-bit register `len_q`. cnt_q bit 16 set means overflow, which forces err=1.
- Only one notification is in flight at a time. Further notifications are back-pressured by ready=0 outside IDLE.
- Outside DATA: `s_axis_tcp_rx.tready`=0 and `m_axis_tcp_rx.tvalid`=0.

## Timing
- While aresetn=0:
  - state=IDLE; all registers cleared.
  - Every valid and ready output is 0; all data outputs are 0.
- After release: `s_tcp_notify.ready`=1 from the first aclk edge.
- Reset asserted mid-operation aborts immediately:
  - No completion record is emitted.
  - A partial output packet is left without tlast; accepted.
- Latencies:
  - Notify handshake to `m_tcp_rd_pkg.valid`: 1 cycle.
  - rd_pkg handshake to rx_meta ready: 1 cycle.
  - Data path: 0 cycles, no buffering.
  - Final tlast handshake to `m_rx_done.valid`: 1 cycle.
  - Completion handshake to notify ready: 1 cycle.
- Handshakes:
  - `m_tcp_rd_pkg` and `m_rx_done` hold valid and data stable until ready. Neither valid depends combinationally on ready.
  - rx_meta arriving before META is back-pressured, never dropped.
- Chunk arithmetic:
  - min() is done on 16-bit unsigned values.
  - The final chunk may be smaller than PKG_BYTES. Example: len=2500, PKG_BYTES=1024 gives chunks of 1024, 1024, 452.
- A beat with tkeep=0 adds 0 bytes and is still forwarded.

## Test plan
- Single chunk: notify {sid=5, len=128}, then rx_meta 5, then 2 full beats with tlast on the second.
  - Expect rd_pkg {5, 128}.
  - Expect 2 output beats, tlast on beat 2.
  - Expect done {5, 128, closed=0, err=0}.
- Multi-chunk: PKG_BYTES=1024, notify len=2500.
  - Expect rd_pkg lens 1024, 1024, 452.
  - Output tlast appears only on the last beat of the third chunk (final tkeep has 4 ones).
  - Expect done bytes=2500, err=0.
- Closed and empty: notify closed=1 on sid=9 gives done {9, 0, closed=1, err=0} with no rd_pkg. Notify len=0 gives no rd_pkg and no done record.
- Errors:
  - rx_meta sid=6 while sid_q=5 gives done err=1.
  - Separately, len=128 with only 100 bytes delivered (tkeep 0xF…F then 36 ones, tlast) gives done bytes=100, err=1.
- Backpressure and reset:
  - Random ready/valid stalls on all channels give identical output data and completion records.
  - A second notify presented during DATA stays unaccepted until DONE completes.
  - aresetn pulsed low mid-DATA drives all valids to 0 asynchronously and returns to IDLE with notify ready=1.
